// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared word width and deframer FSM states for the PISO/SIPO pair
package piso_pkg;

    localparam int PISO_WIDTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } deframe_state_e;

endpackage

// File: rtl/sipo_holding_buf.sv
// rtl/sipo_holding_buf.sv - one-entry valid/ready register slice with overrun detect
module sipo_holding_buf #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             accept,
    output logic             overrun
);

    assign accept  = out_valid & out_ready;
    // A word arriving while the slot is occupied and not draining is lost.
    assign overrun = load & out_valid & ~out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load && !overrun) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
        end else if (accept) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_deframer.sv
// rtl/sipo_deframer.sv - rebuilds MSB-first serial words and delivers them on valid/ready
module sipo_deframer
    import piso_pkg::*;
#(
    parameter  int WIDTH = PISO_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun_err,
    output logic             frame_err,
    input  logic             err_clear
);

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("sipo_deframer: WIDTH must be at least 2");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_BIT  = CNT_W'(1);

    deframe_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_bit;
    logic             word_done;
    logic             frame_abort;
    logic             overrun_evt;
    logic             word_accepted;

    assign shifted   = {shreg_q[WIDTH-2:0], serial_in};
    assign first_bit = {{(WIDTH-1){1'b0}}, serial_in};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        word_done   = 1'b0;
        frame_abort = 1'b0;
        if (serial_valid) begin
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        shreg_d = first_bit;
                        cnt_d   = ONE_BIT;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (frame_start) begin
                        // The partial word is thrown away; this bit is the MSB of a fresh one.
                        frame_abort = 1'b1;
                        shreg_d     = first_bit;
                        cnt_d       = ONE_BIT;
                    end else if (cnt_q == LAST_BIT) begin
                        word_done = 1'b1;
                        shreg_d   = shifted;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        shreg_d = shifted;
                        cnt_d   = cnt_q + ONE_BIT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    sipo_holding_buf #(
        .WIDTH(WIDTH)
    ) u_holding_buf (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (word_done),
        .load_data (shifted),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .accept    (word_accepted),
        .overrun   (overrun_evt)
    );

    // Set beats clear when both land on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overrun_err <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            overrun_err <= overrun_evt | (overrun_err & ~err_clear);
            frame_err   <= frame_abort | (frame_err & ~err_clear);
        end
    end

endmodule

// File: tb/tb_sipo_deframer.sv
// tb/tb_sipo_deframer.sv - table-driven bench for sipo_deframer
module tb_sipo_deframer;

    logic       clock;
    logic       reset_n;
    logic       serial_in;
    logic       serial_valid;
    logic       frame_start;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overrun_err;
    logic       frame_err;
    logic       err_clear;

    int checks = 0;
    int errors = 0;

    sipo_deframer #(.WIDTH(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .frame_start  (frame_start),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun_err  (overrun_err),
        .frame_err    (frame_err),
        .err_clear    (err_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       sv;
        logic       si;
        logic       fs;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic       chkd;
        logic [3:0] ed;
        logic       eo;
        logic       ef;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic sv, logic si, logic fs, logic rdy, logic clr,
                                logic ev, logic chkd, logic [3:0] ed, logic eo, logic ef);
        vec_t v;
        v.sv = sv; v.si = si; v.fs = fs; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.chkd = chkd; v.ed = ed; v.eo = eo; v.ef = ef;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clock);
        serial_valid = v.sv;
        serial_in    = v.si;
        frame_start  = v.fs;
        out_ready    = v.rdy;
        err_clear    = v.clr;
        @(posedge clock);
        #1;
        chk("out_valid", idx, {3'b0, out_valid}, {3'b0, v.ev});
        if (v.chkd) chk("out_data", idx, out_data, v.ed);
        chk("overrun_err", idx, {3'b0, overrun_err}, {3'b0, v.eo});
        chk("frame_err", idx, {3'b0, frame_err}, {3'b0, v.ef});
    endtask

    initial begin
        reset_n      = 1'b0;
        serial_in    = 1'b0;
        serial_valid = 1'b0;
        frame_start  = 1'b0;
        out_ready    = 1'b0;
        err_clear    = 1'b0;

        // args: sv si fs rdy clr | ev chkd ed eo ef
        // clean word 1011
        vecs.push_back(mk(1,1,1,1,0, 0,0,4'h0,0,0));
        vecs.push_back(mk(1,0,0,1,0, 0,0,4'h0,0,0));
        vecs.push_back(mk(1,1,0,1,0, 0,0,4'h0,0,0));
        vecs.push_back(mk(1,1,0,1,0, 1,1,4'hB,0,0));
        vecs.push_back(mk(0,0,0,1,0, 0,0,4'h0,0,0));
        // gapped word 1011
        vecs.push_back(mk(1,1,1,1,0, 0,0,4'h0,0,0));
        vecs.push_back(mk(1,0,0,1,0, 0,0,4'h0,0,0));
        vecs.push_back(mk(0,0,0,1,0, 0,0,4'h0,0,0));
        vecs.push_back(mk(0,1,1,1,0, 0,0,4'h0,0,0));
        vecs.push_back(mk(1,1,0,1,0, 0,0,4'h0,0,0));
        vecs.push_back(mk(1,1,0,1,0, 1,1,4'hB,0,0));
        vecs.push_back(mk(0,0,0,1,0, 0,0,4'h0,0,0));
        // overrun: A held, 5 dropped
        vecs.push_back(mk(1,1,1,0,0, 0,0,4'h0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 0,0,4'h0,0,0));
        vecs.push_back(mk(1,1,0,0,0, 0,0,4'h0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 1,1,4'hA,0,0));
        vecs.push_back(mk(1,0,1,0,0, 1,1,4'hA,0,0));
        vecs.push_back(mk(1,1,0,0,0, 1,1,4'hA,0,0));
        vecs.push_back(mk(1,0,0,0,0, 1,1,4'hA,0,0));
        vecs.push_back(mk(1,1,0,0,0, 1,1,4'hA,1,0));
        vecs.push_back(mk(0,0,0,1,0, 0,0,4'h0,1,0));
        vecs.push_back(mk(0,0,0,0,1, 0,0,4'h0,0,0));
        // simultaneous accept and load
        vecs.push_back(mk(1,1,1,0,0, 0,0,4'h0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 0,0,4'h0,0,0));
        vecs.push_back(mk(1,1,0,0,0, 0,0,4'h0,0,0));
        vecs.push_back(mk(1,0,0,0,0, 1,1,4'hA,0,0));
        vecs.push_back(mk(1,0,1,0,0, 1,1,4'hA,0,0));
        vecs.push_back(mk(1,1,0,0,0, 1,1,4'hA,0,0));
        vecs.push_back(mk(1,0,0,0,0, 1,1,4'hA,0,0));
        vecs.push_back(mk(1,1,0,1,0, 1,1,4'h5,0,0));
        vecs.push_back(mk(0,0,0,1,0, 0,0,4'h0,0,0));
        // frame abort: 1,1 then restart 0,0,1,1
        vecs.push_back(mk(1,1,1,1,0, 0,0,4'h0,0,0));
        vecs.push_back(mk(1,1,0,1,0, 0,0,4'h0,0,0));
        vecs.push_back(mk(1,0,1,1,0, 0,0,4'h0,0,1));
        vecs.push_back(mk(1,0,0,1,0, 0,0,4'h0,0,1));
        vecs.push_back(mk(1,1,0,1,0, 0,0,4'h0,0,1));
        vecs.push_back(mk(1,1,0,1,0, 1,1,4'h3,0,1));
        vecs.push_back(mk(0,0,0,1,1, 0,0,4'h0,0,0));
        // abort coinciding with clear: set wins
        vecs.push_back(mk(1,1,1,1,0, 0,0,4'h0,0,0));
        vecs.push_back(mk(1,0,1,1,1, 0,0,4'h0,0,1));
        vecs.push_back(mk(0,0,0,1,1, 0,0,4'h0,0,0));
        vecs.push_back(mk(1,0,0,1,0, 0,0,4'h0,0,0));
        vecs.push_back(mk(1,1,0,1,0, 0,0,4'h0,0,0));
        vecs.push_back(mk(1,1,0,1,0, 1,1,4'h3,0,0));
        vecs.push_back(mk(0,0,0,1,0, 0,0,4'h0,0,0));
        // bits without frame_start in IDLE are ignored
        vecs.push_back(mk(1,1,0,1,0, 0,0,4'h0,0,0));
        vecs.push_back(mk(1,1,0,1,0, 0,0,4'h0,0,0));
        vecs.push_back(mk(1,1,0,1,0, 0,0,4'h0,0,0));
        vecs.push_back(mk(1,1,0,1,0, 0,0,4'h0,0,0));
        vecs.push_back(mk(0,0,0,1,0, 0,0,4'h0,0,0));

        #12;
        chk("reset out_valid", -1, {3'b0, out_valid}, 4'h0);
        chk("reset out_data", -1, out_data, 4'h0);
        chk("reset overrun_err", -1, {3'b0, overrun_err}, 4'h0);
        chk("reset frame_err", -1, {3'b0, frame_err}, 4'h0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // hold C with frame_err set, then reset mid-word
        apply(mk(1,1,1,0,0, 0,0,4'h0,0,0), 100);
        apply(mk(1,1,1,0,0, 0,0,4'h0,0,1), 101);
        apply(mk(1,1,0,0,0, 0,0,4'h0,0,1), 102);
        apply(mk(1,0,0,0,0, 0,0,4'h0,0,1), 103);
        apply(mk(1,0,0,0,0, 1,1,4'hC,0,1), 104);
        apply(mk(1,1,1,0,0, 1,1,4'hC,0,1), 105);
        apply(mk(1,0,0,0,0, 1,1,4'hC,0,1), 106);
        @(negedge clock);
        serial_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset out_valid", 107, {3'b0, out_valid}, 4'h0);
        chk("async reset out_data", 107, out_data, 4'h0);
        chk("async reset overrun_err", 107, {3'b0, overrun_err}, 4'h0);
        chk("async reset frame_err", 107, {3'b0, frame_err}, 4'h0);
        @(negedge clock);
        reset_n = 1'b1;
        // clean 0110 after release; a leftover partial word would shift the result
        apply(mk(1,0,1,1,0, 0,0,4'h0,0,0), 110);
        apply(mk(1,1,0,1,0, 0,0,4'h0,0,0), 111);
        apply(mk(1,1,0,1,0, 0,0,4'h0,0,0), 112);
        apply(mk(1,0,0,1,0, 1,1,4'h6,0,0), 113);
        apply(mk(0,0,0,1,0, 0,0,4'h0,0,0), 114);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
